it_state_unit: RTL and testbench
================================

# it_state_unit

Thumb-2 If-Then (IT) block tracker that holds the 8-bit ITSTATE register. It is loaded when decode retires an IT instruction, advances once per completed instruction inside the block, and is cleared on flush. Each cycle it supplies the 4-bit condition code for the current instruction to the downstream condition-pass evaluator, which compares it against APSR NZCV.

## Interface
Parameters: none.

Clock and reset (already decided): one clock; reset is synchronous and active-low.

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- it_load  in  1  decode retires an IT instruction this cycle
- it_firstcond  in  4  IT firstcond field, sampled with it_load
- it_mask  in  4  IT mask field, sampled with it_load
- instr_adv  in  1  one instruction completed; advance ITSTATE
- flush  in  1  branch/exception flush; clear ITSTATE
- itstate_restore  in  1  exception-return restore strobe (IT_RESTORE_EN only)
- itstate_restore_val  in  8  value to restore (IT_RESTORE_EN only)
- cur_cond  out  4  condition for current instruction; feeds the condition-pass stage
- in_it  out  1  current instruction is inside an IT block
- last_in_it  out  1  current instruction is the last in the block
- it_remain  out  3  instructions remaining, including current (0–4)
- itstate  out  8  raw ITSTATE, for exception stacking
- it_err  out  1  one-cycle pulse: illegal IT load was rejected

## Operation
- ITSTATE register `st[7:0]`. Reset value is 0x00.
- Decoded outputs are combinational from `st`:
  - in_it = (st[3:0] != 0)
  - cur_cond = in_it ? st[7:4] : 4'b1110 (AL)
  - last_in_it = (st[3:0] == 4'b1000)
  - it_remain = 4 − index of the lowest set bit of st[3:0]: 1000→1, x100→2, xx10→3, xxx1→4, 0000→0.
- Load: `st <= {it_firstcond, it_mask}`.
- Load is rejected, and it_err pulses for the next cycle, when any of these holds:
  - it_mask == 0000
  - it_firstcond == 1111
  - it_firstcond == 1110 and it_mask is not 1000 (AL may not take an E)
  - in_it == 1 (nested IT)
- A rejected load leaves `st` unchanged.
- Advance, applied when instr_adv=1 and in_it=1:
  - if st[2:0] == 000, `st <= 0`
  - otherwise `st[4:0] <= {st[3:0], 1'b0}` and st[7:5] holds.
- instr_adv while in_it=0 has no effect.
- Priority, highest first: rst_n low > flush > itstate_restore > it_load > instr_adv. Only one action applies per cycle.
  - it_load together with instr_adv: the load wins. The IT instruction does not consume a slot.
  - flush together with anything: `st <= 0`, it_err stays 0.
- Reset mid-block clears `st`; outputs read AL / not-in-IT in the next cycle.

## Timing
- All state updates occur on the rising clk edge.
- An action sampled at edge N is visible on the outputs after edge N (cycle N+1). There is no combinational path from inputs to outputs.
- it_err is registered: it is high for exactly the one cycle after the rejected load.
- Output reset values: cur_cond=1110, in_it=0, last_in_it=0, it_remain=0, itstate=0x00, it_err=0.
- The downstream stage sees a new cur_cond one cycle after instr_adv.

## Configuration
- Macro: IT_RESTORE_EN.
- Defined: itstate_restore loads `st <= itstate_restore_val` unconditionally, with no legality check and no it_err.
- Undefined:
  - both restore ports exist but are ignored;
  - the restore priority level is absent;
  - `st` changes only through load, advance, flush and reset.

## Test plan
- **ITTE EQ:** load firstcond=0000, mask=0110, then 3× instr_adv.
  - itstate goes 0x06 → 0x0C → 0x18 → 0x00.
  - cur_cond goes 0000, 0000, 0001, then 1110.
  - it_remain goes 3, 2, 1, then 0.
  - last_in_it is high only at 0x18.
- **Illegal loads:** mask=0000; then firstcond=1111; then firstcond=1110 with mask=0100.
  - Each gives an it_err pulse and itstate stays 0x00.
  - AL with mask=1000 loads 0xE8.
- **Nested IT and same-cycle load/advance:**
  - Load 0x18, then load again while in_it: it_err pulses and st stays 0x18.
  - From idle, assert load and instr_adv together: st = loaded value, not advanced.
- **Flush:** mid-block (st=0x0C), assert flush with instr_adv → st=0x00 next cycle, cur_cond=1110.
- **Reset:** apply rst_n=0 with st=0x46 → all outputs at reset values after the edge, whatever the other inputs are.
- **Restore (with IT_RESTORE_EN):** restore 0xA4 alongside it_load → itstate=0xA4, cur_cond=1010, it_remain=2. Without the macro, itstate remains 0x00.

Source files
------------

// File: rtl/it_state_unit.sv
// Thumb-2 IT block tracker: holds ITSTATE and decodes the current condition.
// Optional macro IT_RESTORE_EN enables the exception-return restore port.
module it_state_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       it_load,
  input  logic [3:0] it_firstcond,
  input  logic [3:0] it_mask,
  input  logic       instr_adv,
  input  logic       flush,
  input  logic       itstate_restore,
  input  logic [7:0] itstate_restore_val,
  output logic [3:0] cur_cond,
  output logic       in_it,
  output logic       last_in_it,
  output logic [2:0] it_remain,
  output logic [7:0] itstate,
  output logic       it_err
);

  logic [7:0] st_reg;
  logic       it_err_reg;
  logic       load_illegal;

`ifndef IT_RESTORE_EN
  logic unused_restore;
  assign unused_restore = itstate_restore ^ (^itstate_restore_val);
`endif

  assign in_it = |st_reg[3:0];

  // AL may only be used with a lone T (mask 1000); nested IT is never legal.
  always_comb begin
    load_illegal = (it_mask == 4'b0000) || (it_firstcond == 4'b1111) ||
                   ((it_firstcond == 4'b1110) && (it_mask != 4'b1000)) || in_it;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_reg     <= 8'h00;
      it_err_reg <= 1'b0;
    end else begin
      it_err_reg <= 1'b0;
      if (flush) begin
        st_reg <= 8'h00;
`ifdef IT_RESTORE_EN
      end else if (itstate_restore) begin
        st_reg <= itstate_restore_val;
`endif
      end else if (it_load) begin
        if (load_illegal) begin
          it_err_reg <= 1'b1;
        end else begin
          st_reg <= {it_firstcond, it_mask};
        end
      end else if (instr_adv && in_it) begin
        if (st_reg[2:0] == 3'b000) begin
          st_reg <= 8'h00;
        end else begin
          // Shifting the mask into bit 4 flips the condition's LSB for E slots.
          st_reg[4:0] <= {st_reg[3:0], 1'b0};
        end
      end
    end
  end

  assign cur_cond   = in_it ? st_reg[7:4] : 4'b1110;
  assign last_in_it = (st_reg[3:0] == 4'b1000);
  assign itstate    = st_reg;
  assign it_err     = it_err_reg;

  always_comb begin
    if (st_reg[0])      it_remain = 3'd4;
    else if (st_reg[1]) it_remain = 3'd3;
    else if (st_reg[2]) it_remain = 3'd2;
    else if (st_reg[3]) it_remain = 3'd1;
    else                it_remain = 3'd0;
  end

endmodule

// File: tb/tb_it_state_unit.sv
// Scoreboard bench for it_state_unit: randomized and directed stimulus
// against a behavioural model of the ITSTATE rules.
module tb_it_state_unit;

  logic       clk;
  logic       rst_n;
  logic       it_load;
  logic [3:0] it_firstcond;
  logic [3:0] it_mask;
  logic       instr_adv;
  logic       flush;
  logic       itstate_restore;
  logic [7:0] itstate_restore_val;
  logic [3:0] cur_cond;
  logic       in_it;
  logic       last_in_it;
  logic [2:0] it_remain;
  logic [7:0] itstate;
  logic       it_err;

  it_state_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .it_load             (it_load),
    .it_firstcond        (it_firstcond),
    .it_mask             (it_mask),
    .instr_adv           (instr_adv),
    .flush               (flush),
    .itstate_restore     (itstate_restore),
    .itstate_restore_val (itstate_restore_val),
    .cur_cond            (cur_cond),
    .in_it               (in_it),
    .last_in_it          (last_in_it),
    .it_remain           (it_remain),
    .itstate             (itstate),
    .it_err              (it_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int       cyc;
    bit [7:0] st;
    bit       err;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_cmp;
  int   n_bad;
  bit [7:0] m_st;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int remain_of(bit [7:0] s);
    for (int i = 0; i < 4; i++) begin
      if (s[i]) return 4 - i;
    end
    return 0;
  endfunction

  function automatic bit legal_load(bit [3:0] fc, bit [3:0] mk, bit [7:0] s);
    if (mk == 0) return 0;
    if (fc == 15) return 0;
    if (fc == 14 && mk != 8) return 0;
    if ((s & 8'h0F) != 0) return 0;
    return 1;
  endfunction

  task automatic chk(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare each expectation in the cycle it targets.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        if (e.cyc < cyc) begin
          chk("missed_slot", cyc, e.cyc);
        end else begin
          chk("itstate", itstate, e.st);
          chk("in_it", in_it, (e.st & 8'h0F) != 0);
          chk("cur_cond", cur_cond, ((e.st & 8'h0F) != 0) ? (e.st >> 4) : 14);
          chk("last_in_it", last_in_it, (e.st & 8'h0F) == 8);
          chk("it_remain", it_remain, remain_of(e.st));
          chk("it_err", it_err, e.err);
        end
      end
    end
  end

  // Drive one cycle of inputs, update the model, queue the expected result.
  task automatic step(bit rn, bit fl, bit rs, bit [7:0] rv, bit ld,
                      bit [3:0] fc, bit [3:0] mk, bit adv);
    exp_t e;
    bit   err;
    @(negedge clk);
    rst_n = rn; flush = fl; itstate_restore = rs; itstate_restore_val = rv;
    it_load = ld; it_firstcond = fc; it_mask = mk; instr_adv = adv;
    err = 0;
    if (!rn) begin
      m_st = 0;
    end else if (fl) begin
      m_st = 0;
`ifdef IT_RESTORE_EN
    end else if (rs) begin
      m_st = rv;
`endif
    end else if (ld) begin
      if (legal_load(fc, mk, m_st)) m_st = {fc, mk};
      else err = 1;
    end else if (adv && (m_st & 8'h0F) != 0) begin
      // Drop one block slot: the remaining mask bits move up one place.
      if ((m_st & 8'h07) == 0) m_st = 0;
      else m_st = (m_st & 8'hE0) | ((m_st << 1) & 8'h1F);
    end
    e.cyc = cyc + 1;
    e.st  = m_st;
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1, 0, 0, 8'h00, 0, 4'h0, 4'h0, 0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; m_st = 0;
    rst_n = 0; flush = 0; itstate_restore = 0; itstate_restore_val = 0;
    it_load = 0; it_firstcond = 0; it_mask = 0; instr_adv = 0;

    step(0, 0, 0, 8'h00, 0, 4'h0, 4'h0, 0);
    step(0, 0, 0, 8'h00, 0, 4'h0, 4'h0, 0);
    idle();
    // ITTE EQ
    step(1, 0, 0, 8'h00, 1, 4'h0, 4'h6, 0);
    repeat (3) step(1, 0, 0, 8'h00, 0, 4'h0, 4'h0, 1);
    idle();
    // Illegal loads, then legal AL
    step(1, 0, 0, 8'h00, 1, 4'h3, 4'h0, 0);
    idle();
    step(1, 0, 0, 8'h00, 1, 4'hF, 4'h8, 0);
    step(1, 0, 0, 8'h00, 1, 4'hE, 4'h4, 0);
    step(1, 0, 0, 8'h00, 1, 4'hE, 4'h8, 0);
    step(1, 0, 0, 8'h00, 0, 4'h0, 4'h0, 1);
    // Nested IT
    step(1, 0, 0, 8'h00, 1, 4'h1, 4'h8, 0);
    step(1, 0, 0, 8'h00, 1, 4'h2, 4'h4, 1);
    step(1, 0, 0, 8'h00, 0, 4'h0, 4'h0, 1);
    // Load with advance from idle
    step(1, 0, 0, 8'h00, 1, 4'h5, 4'hC, 1);
    step(1, 1, 0, 8'h00, 0, 4'h0, 4'h0, 0);
    // Flush mid-block together with advance
    step(1, 0, 0, 8'h00, 1, 4'h0, 4'h6, 0);
    step(1, 0, 0, 8'h00, 0, 4'h0, 4'h0, 1);
    step(1, 1, 0, 8'h00, 1, 4'h3, 4'h8, 1);
    idle();
    // Reset mid-block with other inputs active
    step(1, 0, 0, 8'h00, 1, 4'h4, 4'h6, 0);
    step(0, 0, 1, 8'h77, 1, 4'h2, 4'h8, 1);
    idle();
    // Restore alongside load
    step(1, 0, 1, 8'hA4, 1, 4'h3, 4'h8, 0);
    idle();
    step(1, 1, 0, 8'h00, 0, 4'h0, 4'h0, 0);

    for (int i = 0; i < 2000; i++) begin
      bit [3:0] fc;
      bit [3:0] mk;
      fc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(14, 15)) : 4'($urandom_range(0, 13));
      mk = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      step($urandom_range(0, 40) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0, 8'($urandom),
           $urandom_range(0, 3) == 0, fc, mk, $urandom_range(0, 1) == 1);
    end
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
